// File: rtl/button_event_gen_pkg.sv
// Shared definitions for the button conditioning block.
//   - FSM state encodings (2-bit) for the repeat/long-hold controller
//   - ms_to_cycles(): converts a duration in ms to clock cycles
package btn_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DELAY  = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_DELAY  = ST_DELAY,
    S_REPEAT = ST_REPEAT
  } state_t;

  // Integer divide first so the intermediate product stays small for large clocks.
  function automatic int ms_to_cycles(input int clk_hz, input int ms);
    return clk_hz / 1000 * ms;
  endfunction

endpackage

// File: rtl/button_event_gen_if.sv
// Button event bundle: raw pin in, debounced level and event pulses out.
//   btn_raw       raw asynchronous button pin
//   pressed       debounced level, 1 = held
//   press_pulse   one-cycle pulse on debounced press
//   release_pulse one-cycle pulse on debounced release
//   repeat_pulse  one-cycle auto-repeat pulse while held
//   long_hold     level, high once held past the repeat delay, until release
// master = the side driving the pin and consuming events, slave = the conditioner.
interface button_event_gen_if;
  logic btn_raw;
  logic pressed;
  logic press_pulse;
  logic release_pulse;
  logic repeat_pulse;
  logic long_hold;

  modport master (
    output btn_raw,
    input  pressed, press_pulse, release_pulse, repeat_pulse, long_hold
  );

  modport slave (
    input  btn_raw,
    output pressed, press_pulse, release_pulse, repeat_pulse, long_hold
  );
endinterface

// File: rtl/button_event_gen_sync_debounce.sv
// Two-flop synchronizer, polarity normalization and debounce counter.
//   clk      system clock
//   rst      asynchronous active-high reset
//   btn_raw  raw button pin
//   pressed  debounced level, 1 = held
// pressed only toggles after the normalized input has disagreed with it for
// DB_CYC consecutive cycles; any agreement in between restarts the window.
module sync_debounce
  import btn_pkg::*;
#(
  parameter int DB_CYC     = 4,
  parameter int ACTIVE_LOW = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic pressed
);

  localparam int   DW       = $clog2(DB_CYC + 1);
  localparam logic RELEASED = (ACTIVE_LOW != 0);

  logic          sync1;
  logic          sync2;
  logic          btn_n;
  logic [DW-1:0] db_cnt;

  // XOR with the released level maps the pin to 1 = pressed for either polarity.
  assign btn_n = sync2 ^ RELEASED;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= RELEASED;
      sync2   <= RELEASED;
      db_cnt  <= '0;
      pressed <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      if (btn_n != pressed) begin
        if (db_cnt == DW'(DB_CYC - 1)) begin
          pressed <= ~pressed;
          db_cnt  <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/button_event_gen.sv
// Button conditioner: debounced level plus press/release/auto-repeat pulses
// and a long-hold level for one mechanical button.
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  button_event_gen_if.slave (btn_raw in; pressed, press_pulse,
//        release_pulse, repeat_pulse, long_hold out)
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | released, waiting for a press event
// S_DELAY  | held, counting toward the first repeat / long_hold
// S_REPEAT | long_hold asserted, emitting repeat pulses every RR_CYC cycles
module button_event_gen
  import btn_pkg::*;
#(
  parameter int CLK_HZ          = 12_000_000,
  parameter int DEBOUNCE_MS     = 20,
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_RATE_MS  = 100,
  parameter int REPEAT_EN       = 1,
  parameter int ACTIVE_LOW      = 1
) (
  input logic               clk,
  input logic               rst,
  button_event_gen_if.slave bus
);

  localparam int DB_CYC = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);
  localparam int RD_CYC = ms_to_cycles(CLK_HZ, REPEAT_DELAY_MS);
  localparam int RR_CYC = ms_to_cycles(CLK_HZ, REPEAT_RATE_MS);
  localparam int HW     = $clog2(RD_CYC + 1);
  localparam int RW     = $clog2(RR_CYC + 1);
  localparam logic REP_ON = (REPEAT_EN != 0);

  if (DEBOUNCE_MS < 1 || DB_CYC < 1) begin : g_bad_debounce
    $error("button_event_gen: debounce window must be at least one cycle");
  end
  if (REPEAT_RATE_MS < 1 || RR_CYC < 1) begin : g_bad_rate
    $error("button_event_gen: repeat rate must be at least one cycle");
  end
  if (RD_CYC < 1) begin : g_bad_delay
    $error("button_event_gen: repeat delay must be at least one cycle");
  end

  logic          pressed;
  logic          pressed_q;
  logic          press_ev;
  logic          release_ev;
  state_t        state;
  logic [HW-1:0] hold_cnt;
  logic [HW-1:0] hold_nxt;
  logic [RW-1:0] rate_cnt;
  logic          long_hold_q;
  logic          repeat_q;

  sync_debounce #(
    .DB_CYC     (DB_CYC),
    .ACTIVE_LOW (ACTIVE_LOW)
  ) u_sync_debounce (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (bus.btn_raw),
    .pressed (pressed)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pressed_q <= 1'b0;
    else     pressed_q <= pressed;
  end

  assign press_ev   = pressed & ~pressed_q;
  assign release_ev = ~pressed & pressed_q;

  // DELAY is entered the cycle after press_pulse, so comparing the
  // incremented count lands the first repeat exactly RD_CYC cycles after it.
  assign hold_nxt = hold_cnt + HW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      hold_cnt    <= '0;
      rate_cnt    <= '0;
      long_hold_q <= 1'b0;
      repeat_q    <= 1'b0;
    end else begin
      repeat_q <= 1'b0;
      if (release_ev) begin
        state       <= S_IDLE;
        hold_cnt    <= '0;
        rate_cnt    <= '0;
        long_hold_q <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (press_ev) begin
              hold_cnt <= '0;
              rate_cnt <= '0;
              if (RD_CYC == 1) begin
                state       <= S_REPEAT;
                long_hold_q <= 1'b1;
                repeat_q    <= REP_ON;
              end else begin
                state <= S_DELAY;
              end
            end
          end
          S_DELAY: begin
            hold_cnt <= hold_nxt;
            if (hold_nxt == HW'(RD_CYC - 1)) begin
              state       <= S_REPEAT;
              long_hold_q <= 1'b1;
              repeat_q    <= REP_ON;
              rate_cnt    <= '0;
            end
          end
          S_REPEAT: begin
            if (rate_cnt == RW'(RR_CYC - 1)) begin
              repeat_q <= REP_ON;
              rate_cnt <= '0;
            end else begin
              rate_cnt <= rate_cnt + 1'b1;
            end
          end
          default: begin
            state       <= S_IDLE;
            hold_cnt    <= '0;
            rate_cnt    <= '0;
            long_hold_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.pressed       = pressed;
  assign bus.press_pulse   = press_ev;
  assign bus.release_pulse = release_ev;
  // The repeat decision is registered a cycle before pressed can be seen
  // falling; gating with pressed drops a repeat that lands on the release cycle.
  assign bus.repeat_pulse  = repeat_q & pressed;
  assign bus.long_hold     = long_hold_q;

endmodule

// File: doc/button_event_gen.md
Name: button_event_gen

Overview:
- Upstream conditioning stage for the counter FSM's go/reset inputs.
- Takes a raw mechanical button and produces a clean level plus single-cycle event pulses: press, release, auto-repeat.
- One instance per button. The FSM consumes press_pulse directly, with no extra edge detection downstream.

Parameters:
- CLK_HZ, 12_000_000, system clock frequency in Hz.
- DEBOUNCE_MS, 20, stability window in ms. Must be ≥1 (elaboration error otherwise).
- REPEAT_DELAY_MS, 500, hold time from press_pulse to first repeat_pulse.
- REPEAT_RATE_MS, 100, period between subsequent repeat_pulse. Must be ≥1.
- REPEAT_EN, 1, 0 disables repeat_pulse; long_hold still operates.
- ACTIVE_LOW, 1, 1 means btn_raw=0 is pressed.

Ports:
- clk  in  1  system clock, all logic posedge.
- rst  in  1  asynchronous, active-high reset.
- btn_raw  in  1  raw asynchronous button pin.
- pressed  out  1  debounced level, 1 = held.
- press_pulse  out  1  one-cycle pulse on debounced press.
- release_pulse  out  1  one-cycle pulse on debounced release.
- repeat_pulse  out  1  one-cycle auto-repeat pulse while held.
- long_hold  out  1  level, high once held ≥ REPEAT_DELAY_MS, until release.

Behaviour:
- Derived constants:
  - DB_CYC = CLK_HZ/1000*DEBOUNCE_MS, RD_CYC = CLK_HZ/1000*REPEAT_DELAY_MS, RR_CYC = CLK_HZ/1000*REPEAT_RATE_MS.
  - Counter widths are $clog2(max+1). Counters saturate and never wrap.
- Reset: all outputs 0. Synchronizer flops reset to the released pin level (ACTIVE_LOW ? 1 : 0). Counters 0, FSM IDLE.
- Synchronizer: 2 flops, then polarity normalization to btn_n (1 = pressed).
- Debounce:
  - db_cnt increments each cycle btn_n != pressed, and clears when they are equal.
  - When db_cnt reaches DB_CYC-1 while still mismatched, pressed toggles and db_cnt clears.
  - Any bounce back before that point restarts the window.
- Latency: a btn_raw change first sampled at edge k gives pressed changing at edge k+1+DB_CYC. The matching pulse is high in the cycle after that edge.
- press_pulse / release_pulse = rising / falling edge of pressed (registered compare), exactly 1 cycle each.
- FSM states: IDLE, DELAY, REPEAT.
  - IDLE: on press event → DELAY, hold_cnt=0.
  - DELAY: hold_cnt++. At hold_cnt == RD_CYC-1 → REPEAT, long_hold=1, repeat_pulse=REPEAT_EN, rate_cnt=0.
  - REPEAT: rate_cnt++. At rate_cnt == RR_CYC-1 → repeat_pulse=REPEAT_EN, rate_cnt=0.
  - Release event in any state → IDLE, long_hold=0, counters cleared. No repeat_pulse in the release cycle.
  - Unused encoding → IDLE.
- Simultaneous events:
  - A release in the same cycle a repeat would fire suppresses the repeat.
  - press_pulse and repeat_pulse are never high together, since RD_CYC ≥ 1.
- Reset mid-hold: outputs drop immediately (async). If the button is still held after reset deasserts, it counts as a fresh press: press_pulse after the full debounce latency.

Decomposition:
- Package btn_pkg holds:
  - FSM state localparams (2-bit encoding).
  - Function ms_to_cycles(clk_hz, ms).
- Sub-module sync_debounce holds the 2-flop synchronizer, polarity normalization and DB counter. Output: pressed.
- Top holds edge pulses and the repeat FSM.

Test Plan:
Bench parameters: CLK_HZ=1000, DEBOUNCE_MS=4, REPEAT_DELAY_MS=10, REPEAT_RATE_MS=5, ACTIVE_LOW=1. This gives DB_CYC=4, RD_CYC=10, RR_CYC=5.

1. Clean press: btn_raw 1→0, first sampled at edge 0, held 12 cycles → pressed rises at edge 5; press_pulse high exactly 1 cycle; no repeat_pulse; long_hold stays 0.
2. Bounce rejection: btn_raw low 3 cycles, high 2, low 3, then high → pressed, press_pulse and release_pulse stay 0 throughout.
3. Auto-repeat: hold 40 cycles → press_pulse at cycle P; repeat_pulse at P+10, P+15, P+20…; long_hold high from P+10; after release, one release_pulse (debounce latency later) and long_hold=0.
4. REPEAT_EN=0, same hold → long_hold asserts at P+10; repeat_pulse never asserts.
5. Release coinciding with a repeat: release timed so pressed falls on the edge where the P+15 repeat would fire → release_pulse only; no repeat_pulse; FSM returns to IDLE.
6. Reset mid-hold: assert rst at P+12 for 2 cycles, button still held → all outputs 0 immediately; press_pulse again 5 cycles after rst deasserts.
